sample_arbiter: RTL



---
 rtl/sample_arbiter_pkg.sv | 18 +
 rtl/sample_arbiter_rr_pick.sv | 36 +++
 rtl/sample_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sample_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin sample arbiter.
package sample_arbiter_pkg;

  // Ownership state: free arbitration or a locked burst owner
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Burst counter is sized for the largest legal MAX_BURST (255)
  localparam int unsigned CNT_W = 8;

  // Index width for n requesters (at least one bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_arbiter_rr_pick.sv
// Rotating-priority picker: first requester after ptr, searched circularly.
module sample_arbiter_rr_pick
  import sample_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  // Walk ptr+1, ptr+2, ... wrapping at N; first asserted request wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/sample_arbiter.sv
// Round-robin arbiter feeding one registered capture stage, with bounded
// lock bursts that let a requester keep ownership for back-to-back words.
module sample_arbiter
  import sample_arbiter_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          lock,
  input  logic [N*W-1:0]        data,
  output logic [N-1:0]          grant,
  output logic [W-1:0]          out_data,
  output logic [idx_w(N)-1:0]   out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned IW = idx_w(N);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      data_q;
  logic [IW-1:0]     src_q;
  logic              valid_q;

  logic [W-1:0]      words [N];
  logic              slot_free;
  logic [N-1:0]      pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [N-1:0]      gnt;
  logic [IW-1:0]     xfer_idx;
  logic              xfer;
  logic              keep_lock;
  logic              release_owner;

  // Unpack the flat requester bus into per-requester words
  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = data[i*W +: W];
  end

  sample_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign slot_free = !valid_q || out_ready;

  // Grant decode: round robin when idle, owner only when locked, nothing in reset
  always_comb begin
    gnt      = '0;
    xfer_idx = pick_idx;
    if (rst_n && slot_free) begin
      if (state_q == IDLE) begin
        if (pick_any) gnt = pick_gnt;
      end else begin
        xfer_idx = owner_q;
        if (req[owner_q]) gnt[owner_q] = 1'b1;
      end
    end
  end

  assign xfer          = |gnt;
  assign cnt_d         = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign keep_lock     = lock[xfer_idx] && (32'(cnt_d) < MAX_BURST);
  assign release_owner = slot_free && (state_q == OWNED) && !xfer;

  // Next ownership state: lock sampled only on a transfer, owner dropout releases
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = keep_lock ? OWNED : IDLE;
    end else if (release_owner) begin
      state_d = IDLE;
    end
  end

  // State, round-robin pointer, burst owner/count and capture register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        data_q  <= words[xfer_idx];
        src_q   <= xfer_idx;
        valid_q <= 1'b1;
        ptr_q   <= xfer_idx;
        owner_q <= xfer_idx;
        cnt_q   <= keep_lock ? cnt_d : '0;
      end else begin
        if (out_ready) valid_q <= 1'b0;
        if (release_owner) cnt_q <= '0;
      end
    end
  end

  assign grant     = gnt;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule
